// File: rtl/param_mux_scanner.sv
// param_mux_scanner
//   Registered N_IN-way channel multiplexer with a manual select mode and an
//   automatic scan mode. In scan mode each channel is held for SCAN_DIV
//   cycles, then the select advances (wrapping N_IN-1 -> 0) and scan_tick
//   pulses for one cycle. hold freezes scan progress without stopping the
//   data path: data_out keeps following the held channel.
//
// Ports
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset
//   data_in   : N_IN*W bits, channel k at [k*W +: W]
//   sel       : manual channel select
//   mode      : 0 = manual, 1 = scan
//   hold      : freeze scan progress (ignored in manual)
//   data_out  : registered data of channel cur_sel (zero if out of range)
//   cur_sel   : registered channel index driving data_out
//   sel_err   : registered flag, cur_sel >= N_IN
//   scan_tick : one-cycle pulse after each scan advance
module param_mux_scanner #(
  parameter int N_IN     = 7,
  parameter int W        = 1,
  parameter int SCAN_DIV = 8,
  localparam int SEL_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [N_IN*W-1:0]   data_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                hold,
  output logic [W-1:0]        data_out,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                sel_err,
  output logic                scan_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  // Range check done one bit wider so N_IN == 2**SEL_W compares correctly.
  localparam logic [SEL_W:0]   N_IN_X     = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

  logic [1:0]             state, state_nx;
  logic [CNT_W-1:0]       dwell, dwell_nx;
  logic [SEL_W-1:0]       cur_sel_nx;
  logic                   tick_nx;
  logic                   in_range;
  logic [N_IN-1:0][W-1:0] ch;

  assign ch       = data_in;
  assign in_range = ({1'b0, cur_sel} < N_IN_X);

  // Priority: mode=0 beats everything (including a terminal count), then
  // scan entry, then hold, then normal counting. PAUSE is left on the same
  // edge hold drops, so the dwell count resumes from its held value on that
  // very edge rather than losing a cycle.
  always_comb begin
    state_nx   = state;
    dwell_nx   = dwell;
    cur_sel_nx = cur_sel;
    tick_nx    = 1'b0;
    if (!mode) begin
      state_nx   = ST_MANUAL;
      dwell_nx   = '0;
      cur_sel_nx = sel;
    end else if (state == ST_MANUAL) begin
      state_nx = ST_SCAN;
      dwell_nx = '0;
      if (!in_range) cur_sel_nx = '0;
    end else if (hold) begin
      state_nx = ST_PAUSE;
    end else begin
      state_nx = ST_SCAN;
      if (dwell == DWELL_LAST) begin
        dwell_nx   = '0;
        tick_nx    = 1'b1;
        cur_sel_nx = (cur_sel >= SEL_LAST) ? '0 : cur_sel + 1'b1;
      end else begin
        dwell_nx = dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_MANUAL;
      dwell     <= '0;
      cur_sel   <= '0;
      scan_tick <= 1'b0;
      data_out  <= '0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      dwell     <= dwell_nx;
      cur_sel   <= cur_sel_nx;
      scan_tick <= tick_nx;
      // Data path uses the registered index, hence two cycles sel->data_out.
      data_out  <= in_range ? ch[cur_sel] : '0;
      sel_err   <= !in_range;
    end
  end

endmodule

// File: tb/tb_param_mux_scanner.sv
module tb_param_mux_scanner;
  localparam int N_IN     = 7;
  localparam int W        = 1;
  localparam int SCAN_DIV = 8;
  localparam int SEL_W    = 3;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [N_IN*W-1:0] data_in = '0;
  logic [SEL_W-1:0]  sel = '0;
  logic              mode = 1'b0;
  logic              hold = 1'b0;
  logic [W-1:0]      data_out;
  logic [SEL_W-1:0]  cur_sel;
  logic              sel_err;
  logic              scan_tick;

  int tests = 0;
  int fails = 0;

  // Reference model: scanning flag (covers scan and pause), dwell count,
  // selected channel and the expected registered outputs.
  bit m_scan;
  int m_cnt, m_sel, m_out, m_err, m_tick;

  param_mux_scanner #(.N_IN(N_IN), .W(W), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel),
    .mode(mode), .hold(hold), .data_out(data_out), .cur_sel(cur_sel),
    .sel_err(sel_err), .scan_tick(scan_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_scan = 0; m_cnt = 0; m_sel = 0; m_out = 0; m_err = 0; m_tick = 0;
  endtask

  task automatic mdl_edge();
    int old;
    old    = m_sel;
    m_out  = (old < N_IN) ? int'((data_in >> (old * W)) & ((1 << W) - 1)) : 0;
    m_err  = (old >= N_IN) ? 1 : 0;
    m_tick = 0;
    if (!mode) begin
      m_scan = 0; m_cnt = 0; m_sel = int'(sel);
    end else if (!m_scan) begin
      m_scan = 1; m_cnt = 0;
      if (m_sel >= N_IN) m_sel = 0;
    end else if (!hold) begin
      m_cnt++;
      if (m_cnt == SCAN_DIV) begin
        m_cnt = 0; m_sel = (m_sel + 1) % N_IN; m_tick = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    mdl_edge();
    #1;
    chk("cur_sel",   32'(cur_sel),   32'(m_sel));
    chk("data_out",  32'(data_out),  32'(m_out));
    chk("sel_err",   32'(sel_err),   32'(m_err));
    chk("scan_tick", 32'(scan_tick), 32'(m_tick));
  endtask

  // Called just after a check point: pulse reset between clock edges.
  task automatic async_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_cur_sel"},   32'(cur_sel),   0);
    chk({tag, "_data_out"},  32'(data_out),  0);
    chk({tag, "_sel_err"},   32'(sel_err),   0);
    chk({tag, "_scan_tick"}, 32'(scan_tick), 0);
    mdl_reset();
    #1 resetn = 1'b1;
  endtask

  initial begin
    int ticks;
    int held;
    mdl_reset();
    // Reset state, observed after an edge with reset still asserted.
    #7;
    chk("rst_cur_sel",   32'(cur_sel),   0);
    chk("rst_data_out",  32'(data_out),  0);
    chk("rst_sel_err",   32'(sel_err),   0);
    chk("rst_scan_tick", 32'(scan_tick), 0);
    #5 resetn = 1'b1;

    // Manual select.
    data_in = 7'b1010110; sel = 3'd3;
    step(); chk("man_cur_sel3", 32'(cur_sel), 3);
    step(); chk("man_data3", 32'(data_out), 0);
    sel = 3'd2;
    step(); step(); chk("man_data2", 32'(data_out), 1);

    // Out of range select.
    sel = 3'd7;
    step(); chk("oor_cur_sel", 32'(cur_sel), 7);
    step(); chk("oor_data", 32'(data_out), 0); chk("oor_err", 32'(sel_err), 1);
    sel = 3'd6;
    step(); step(); chk("oor_err_clr", 32'(sel_err), 0);

    // Scan wrap from channel 5: 5,6,0,1.
    sel = 3'd5;
    step();
    mode = 1'b1;
    step(); chk("scan_entry", 32'(cur_sel), 5);
    ticks = 0;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      step();
      ticks += int'(scan_tick);
      if (i == SCAN_DIV - 2)     chk("scan_pre_adv", 32'(cur_sel), 5);
      if (i == SCAN_DIV - 1)     chk("scan_adv6", 32'(cur_sel), 6);
      if (i == 2 * SCAN_DIV - 1) chk("scan_wrap0", 32'(cur_sel), 0);
    end
    chk("scan_ticks", 32'(ticks), 3);
    chk("scan_adv1", 32'(cur_sel), 1);

    // Pause at dwell count 3 for 20 cycles.
    step(); step(); step();
    hold = 1'b1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(scan_tick);
    end
    chk("pause_sel", 32'(cur_sel), 1);
    chk("pause_ticks", 32'(ticks), 0);
    hold = 1'b0;
    held = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cur_sel != 3'd1) held++;
    end
    chk("pause_early_adv", 32'(held), 0);
    step(); chk("pause_resume_adv", 32'(cur_sel), 2);

    // mode=0 on the terminal-count cycle.
    for (int i = 0; i < SCAN_DIV - 1; i++) step();
    mode = 1'b0; sel = 3'd6;
    step();
    chk("prio_sel", 32'(cur_sel), 6);
    chk("prio_tick", 32'(scan_tick), 0);

    // Async reset mid-scan at channel 4.
    sel = 3'd4;
    step();
    mode = 1'b1;
    step(); step(); step(); step();
    chk("rst_pre_sel", 32'(cur_sel), 4);
    async_reset("arst");
    // Restart from MANUAL: entry edge, then a full dwell before advancing.
    for (int i = 0; i <= SCAN_DIV; i++) step();
    chk("arst_restart", 32'(cur_sel), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 14) == 0) hold = ~hold;
      sel     = SEL_W'($urandom_range(0, 7));
      data_in = N_IN'($urandom);
      if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_mux_scanner.md
PARAM_MUX_SCANNER -- requirements
Module: param_mux_scanner

Interface
REQ-001 The block SHALL take parameter N_IN, default 7: number of input channels, legal range 2..64.
REQ-002 The block SHALL take parameter W, default 1: data width per channel, legal range 1..32.
REQ-003 The block SHALL take parameter SCAN_DIV, default 8: clock cycles per channel dwell in scan mode, legal range >= 2.
REQ-004 The block SHALL derive localparam SEL_W = clog2(N_IN), with a minimum of 1.
REQ-005 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port data_in, input, N_IN*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-008 The block SHALL have port sel, input, SEL_W bits: manual channel select.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = manual, 1 = scan.
REQ-010 The block SHALL have port hold, input, 1 bit: freeze scan progress.
REQ-011 The block SHALL have port data_out, output, W bits: registered selected channel data.
REQ-012 The block SHALL have port cur_sel, output, SEL_W bits: registered channel index currently driving data_out.
REQ-013 The block SHALL have port sel_err, output, 1 bit: registered flag that cur_sel is out of range.
REQ-014 The block SHALL have port scan_tick, output, 1 bit: one-cycle pulse on each scan advance.

Function
REQ-015 The FSM SHALL have states MANUAL, SCAN and PAUSE, held in a registered state variable.
REQ-016 Transitions SHALL be:
- MANUAL->SCAN when mode=1;
- SCAN->PAUSE when mode=1 and hold=1;
- PAUSE->SCAN when mode=1 and hold=0;
- SCAN or PAUSE->MANUAL when mode=0.
REQ-017 In MANUAL, cur_sel SHALL load sel every cycle, so sel reaches cur_sel after 1 cycle.
REQ-018 data_out SHALL load channel cur_sel of data_in every cycle, so sel reaches data_out after 2 cycles.
REQ-019 If cur_sel >= N_IN, data_out SHALL load all zeros and sel_err SHALL load 1; otherwise sel_err SHALL load 0.
REQ-020 In SCAN, a dwell counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-021 On each SCAN cycle where the dwell counter equals SCAN_DIV-1:
- cur_sel SHALL advance by 1;
- cur_sel SHALL wrap from N_IN-1 to 0;
- scan_tick SHALL be 1 on the following cycle only.
REQ-022 On entry to SCAN from MANUAL, the dwell counter SHALL clear to 0 and scanning SHALL continue from the current cur_sel.
REQ-023 If cur_sel is out of range on entry to SCAN, cur_sel SHALL load 0.
REQ-024 In PAUSE, the dwell counter and cur_sel SHALL hold their values, scan_tick SHALL be 0, and data_out SHALL keep tracking data_in of the held channel.
REQ-025 On leaving PAUSE, the dwell count SHALL resume from its held value and SHALL NOT restart.
REQ-026 On entry to MANUAL, the dwell counter SHALL clear to 0 and scan_tick SHALL be 0.
REQ-027 If mode goes to 0 on the same cycle as a terminal count, MANUAL SHALL take priority: no advance and no scan_tick.
REQ-028 If hold and a terminal count occur on the same cycle, hold SHALL take priority: no advance.
REQ-029 hold SHALL be ignored in MANUAL.
REQ-030 The dwell counter SHALL be clog2(SCAN_DIV) bits wide and SHALL never exceed SCAN_DIV-1.

Reset
REQ-031 While resetn=0, independent of clock, the block SHALL force state=MANUAL, cur_sel=0, dwell counter=0, data_out=0, sel_err=0 and scan_tick=0.
REQ-032 Reset asserted mid-scan SHALL abort the scan immediately.
REQ-033 After resetn deasserts, the first rising edge SHALL apply normal MANUAL or SCAN rules starting from the reset values.

Verification
REQ-034 Manual select: N_IN=7, W=1, data_in=7'b1010110, sel=3 -> cur_sel=3 after 1 clk, data_out=0 after 2 clk; sel=2 -> data_out=1 two clk later.
REQ-035 Out of range: N_IN=7, sel=7 -> cur_sel=7, data_out=0, sel_err=1; sel=6 -> sel_err=0 two clk later.
REQ-036 Scan wrap: N_IN=7, SCAN_DIV=8, mode=1 from cur_sel=5 -> cur_sel sequence 5,6,0,1 with a change every 8 clk and one scan_tick per change.
REQ-037 Pause: SCAN_DIV=8, hold=1 for 20 clk at dwell count 3 -> cur_sel unchanged, scan_tick=0; after hold=0, advance occurs exactly 5 clk later.
REQ-038 Priority: mode=0 asserted on the terminal-count cycle -> no advance, no scan_tick, and cur_sel=sel on the next clk.
REQ-039 Async reset: resetn pulsed low between clock edges mid-scan with cur_sel=4 -> all outputs 0 before the next edge; state=MANUAL after release.
